// File: rtl/mips_reg_write_scheduler_pkg.sv
// Shared constants and types for the MIPS register-file writeback scheduler.
package mips_reg_write_scheduler_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 5;
    localparam int unsigned NUM_REGS   = 32'd1 << ADDR_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] REG_ZERO = '0;

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/mips_rr_arbiter2.sv
// Two-requester round-robin arbiter; a tie goes to the requester not granted last.
module mips_rr_arbiter2
    import mips_reg_write_scheduler_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_alu,
    input  logic req_mem,
    output logic gnt_alu_c,
    output logic gnt_mem_c
);

    grant_e last_grant;
    grant_e last_grant_nxt;

    // Reset to MEM so the first tie after reset goes to ALU.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= GRANT_MEM;
        end else begin
            last_grant <= last_grant_nxt;
        end
    end

    // No grants while reset is held.
    always_comb begin
        gnt_alu_c      = 1'b0;
        gnt_mem_c      = 1'b0;
        last_grant_nxt = last_grant;
        if (!reset) begin
            if (req_alu && (!req_mem || last_grant == GRANT_MEM)) begin
                gnt_alu_c = 1'b1;
            end else if (req_mem) begin
                gnt_mem_c = 1'b1;
            end
            if (gnt_alu_c) begin
                last_grant_nxt = GRANT_ALU;
            end else if (gnt_mem_c) begin
                last_grant_nxt = GRANT_MEM;
            end
        end
    end

endmodule

// File: rtl/mips_reg_write_scheduler.sv
// Arbitrates the register-file write port between ALU and load writeback and
// tracks outstanding destinations so decode can stall on a busy source.
module mips_reg_write_scheduler
    import mips_reg_write_scheduler_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_reg,
    input  logic                  alu_valid,
    input  logic [ADDR_WIDTH-1:0] alu_reg,
    input  logic [DATA_WIDTH-1:0] alu_data,
    output logic                  alu_ready,
    input  logic                  mem_valid,
    input  logic [ADDR_WIDTH-1:0] mem_reg,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_ready,
    input  logic [ADDR_WIDTH-1:0] read_reg_1,
    input  logic [ADDR_WIDTH-1:0] read_reg_2,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic [ADDR_WIDTH-1:0] write_reg,
    output logic                  signal_reg_write,
    output logic [NUM_REGS-1:0]   pending
);

    logic          alu_gnt_c;
    logic          mem_gnt_c;
    logic          grant_c;
    wb_req_t       win_c;
    logic [NUM_REGS-1:0] pending_nxt;
    logic          busy_1_c;
    logic          busy_2_c;

    mips_rr_arbiter2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_alu   (alu_valid),
        .req_mem   (mem_valid),
        .gnt_alu_c (alu_gnt_c),
        .gnt_mem_c (mem_gnt_c)
    );

    assign alu_ready = alu_gnt_c;
    assign mem_ready = mem_gnt_c;
    assign grant_c   = alu_gnt_c | mem_gnt_c;

    // Select the granted requester's payload.
    always_comb begin
        win_c = '{rd: mem_reg, data: mem_data};
        if (alu_gnt_c) begin
            win_c = '{rd: alu_reg, data: alu_data};
        end
    end

    // Write stage: one-cycle enable pulse per grant, suppressed for register 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_data       <= '0;
            write_reg        <= '0;
            signal_reg_write <= 1'b0;
        end else if (grant_c) begin
            write_data       <= win_c.data;
            write_reg        <= win_c.rd;
            signal_reg_write <= (win_c.rd != REG_ZERO);
        end else begin
            signal_reg_write <= 1'b0;
        end
    end

    // Scoreboard: clear on grant, then set on issue so a newer producer wins.
    always_comb begin
        pending_nxt = pending;
        if (grant_c && win_c.rd != REG_ZERO) begin
            pending_nxt[win_c.rd] = 1'b0;
        end
        if (issue_valid && issue_reg != REG_ZERO) begin
            pending_nxt[issue_reg] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    // A source is busy while pending or while its write is still in the write stage.
    assign busy_1_c = (read_reg_1 != REG_ZERO) &&
                      (pending[read_reg_1] || (signal_reg_write && write_reg == read_reg_1));
    assign busy_2_c = (read_reg_2 != REG_ZERO) &&
                      (pending[read_reg_2] || (signal_reg_write && write_reg == read_reg_2));
    assign stall    = busy_1_c | busy_2_c;

endmodule

// File: tb/tb_mips_reg_write_scheduler.sv
// Directed testbench for mips_reg_write_scheduler.
module tb_mips_reg_write_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_reg;
    logic        alu_valid;
    logic [4:0]  alu_reg;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_reg;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic [4:0]  read_reg_1;
    logic [4:0]  read_reg_2;
    logic        stall;
    logic [31:0] write_data;
    logic [4:0]  write_reg;
    logic        signal_reg_write;
    logic [31:0] pending;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mips_reg_write_scheduler dut (
        .clk              (clk),
        .reset            (reset),
        .issue_valid      (issue_valid),
        .issue_reg        (issue_reg),
        .alu_valid        (alu_valid),
        .alu_reg          (alu_reg),
        .alu_data         (alu_data),
        .alu_ready        (alu_ready),
        .mem_valid        (mem_valid),
        .mem_reg          (mem_reg),
        .mem_data         (mem_data),
        .mem_ready        (mem_ready),
        .read_reg_1       (read_reg_1),
        .read_reg_2       (read_reg_2),
        .stall            (stall),
        .write_data       (write_data),
        .write_reg        (write_reg),
        .signal_reg_write (signal_reg_write),
        .pending          (pending)
    );

    task automatic clear_inputs();
        issue_valid = 1'b0; issue_reg = 5'd0;
        alu_valid = 1'b0; alu_reg = 5'd0; alu_data = 32'd0;
        mem_valid = 1'b0; mem_reg = 5'd0; mem_data = 32'd0;
        read_reg_1 = 5'd0; read_reg_2 = 5'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        alu_valid = 1'b1;
        mem_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (pending !== 32'h0) begin n_errors++; $display("FAIL reset_pending: got %h expected %h", pending, 32'h0); end
        n_checks++; if (signal_reg_write !== 1'b0) begin n_errors++; $display("FAIL reset_srw: got %b expected 0", signal_reg_write); end
        n_checks++; if (write_reg !== 5'd0) begin n_errors++; $display("FAIL reset_write_reg: got %0d expected 0", write_reg); end
        n_checks++; if (write_data !== 32'h0) begin n_errors++; $display("FAIL reset_write_data: got %h expected 0", write_data); end
        n_checks++; if ({alu_ready, mem_ready} !== 2'b00) begin n_errors++; $display("FAIL reset_ready: got %b expected 00", {alu_ready, mem_ready}); end
        n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
        @(negedge clk);
        clear_inputs();
        reset = 1'b0;
    endtask

    task automatic test_alu_only();
        @(negedge clk);
        alu_valid = 1'b1; alu_reg = 5'd30; alu_data = 32'hFF003FFF;
        #1;
        n_checks++; if (alu_ready !== 1'b1) begin n_errors++; $display("FAIL alu_only_ready: got %b expected 1", alu_ready); end
        n_checks++; if (mem_ready !== 1'b0) begin n_errors++; $display("FAIL alu_only_mem_ready: got %b expected 0", mem_ready); end
        @(posedge clk); #1;
        n_checks++; if (signal_reg_write !== 1'b1) begin n_errors++; $display("FAIL alu_only_srw: got %b expected 1", signal_reg_write); end
        n_checks++; if (write_reg !== 5'd30) begin n_errors++; $display("FAIL alu_only_write_reg: got %0d expected 30", write_reg); end
        n_checks++; if (write_data !== 32'hFF003FFF) begin n_errors++; $display("FAIL alu_only_write_data: got %h expected ff003fff", write_data); end
        @(negedge clk);
        alu_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (signal_reg_write !== 1'b0) begin n_errors++; $display("FAIL alu_only_srw_drop: got %b expected 0", signal_reg_write); end
    endtask

    task automatic test_round_robin();
        logic       exp_alu;
        logic [4:0] exp_reg;
        logic [31:0] exp_data;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'h0000_0A1A;
            mem_valid = 1'b1; mem_reg = 5'd6; mem_data = 32'h0000_0B1B;
            exp_alu  = (i % 2 == 0);
            exp_reg  = exp_alu ? 5'd5 : 5'd6;
            exp_data = exp_alu ? 32'h0000_0A1A : 32'h0000_0B1B;
            #1;
            n_checks++; if ({alu_ready, mem_ready} !== {exp_alu, ~exp_alu}) begin n_errors++; $display("FAIL rr_ready_%0d: got %b expected %b", i, {alu_ready, mem_ready}, {exp_alu, ~exp_alu}); end
            @(posedge clk); #1;
            n_checks++; if (signal_reg_write !== 1'b1 || write_reg !== exp_reg || write_data !== exp_data) begin
                n_errors++; $display("FAIL rr_write_%0d: got srw=%b reg=%0d data=%h expected srw=1 reg=%0d data=%h", i, signal_reg_write, write_reg, write_data, exp_reg, exp_data);
            end
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_stall();
        @(negedge clk);
        issue_valid = 1'b1; issue_reg = 5'd31;
        @(negedge clk);
        issue_valid = 1'b0; read_reg_1 = 5'd31;
        #1;
        n_checks++; if (pending !== 32'h8000_0000) begin n_errors++; $display("FAIL stall_pending_set: got %h expected 80000000", pending); end
        n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL stall_pending: got %b expected 1", stall); end
        @(negedge clk);
        alu_valid = 1'b1; alu_reg = 5'd31; alu_data = 32'h1234_5678;
        #1;
        n_checks++; if (stall !== 1'b1 || alu_ready !== 1'b1) begin n_errors++; $display("FAIL stall_at_grant: got stall=%b ready=%b expected 1 1", stall, alu_ready); end
        @(negedge clk);
        alu_valid = 1'b0;
        #1;
        n_checks++; if (stall !== 1'b1 || pending !== 32'h0 || signal_reg_write !== 1'b1) begin
            n_errors++; $display("FAIL stall_in_flight: got stall=%b pending=%h srw=%b expected 1 00000000 1", stall, pending, signal_reg_write);
        end
        @(posedge clk); #1;
        n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL stall_release: got %b expected 0", stall); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_reg_zero();
        @(negedge clk);
        issue_valid = 1'b1; issue_reg = 5'd3;
        @(negedge clk);
        issue_valid = 1'b1; issue_reg = 5'd0;
        mem_valid = 1'b1; mem_reg = 5'd0; mem_data = 32'hDEADBEEF;
        #1;
        n_checks++; if (mem_ready !== 1'b1) begin n_errors++; $display("FAIL zero_mem_ready: got %b expected 1", mem_ready); end
        @(posedge clk); #1;
        n_checks++; if (signal_reg_write !== 1'b0) begin n_errors++; $display("FAIL zero_srw: got %b expected 0", signal_reg_write); end
        n_checks++; if (pending !== 32'h0000_0008) begin n_errors++; $display("FAIL zero_pending: got %h expected 00000008", pending); end
        n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL zero_stall: got %b expected 0", stall); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_set_clear_same_cycle();
        @(negedge clk);
        issue_valid = 1'b1; issue_reg = 5'd7;
        @(negedge clk);
        issue_valid = 1'b1; issue_reg = 5'd7;
        alu_valid = 1'b1; alu_reg = 5'd7; alu_data = 32'h0000_0777;
        #1;
        n_checks++; if (alu_ready !== 1'b1 || pending !== 32'h0000_0088) begin n_errors++; $display("FAIL same_pre: got ready=%b pending=%h expected 1 00000088", alu_ready, pending); end
        @(posedge clk); #1;
        n_checks++; if (pending !== 32'h0000_0088) begin n_errors++; $display("FAIL same_pending: got %h expected 00000088", pending); end
        n_checks++; if (signal_reg_write !== 1'b1 || write_reg !== 5'd7) begin n_errors++; $display("FAIL same_write: got srw=%b reg=%0d expected 1 7", signal_reg_write, write_reg); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        @(negedge clk);
        issue_valid = 1'b1; issue_reg = 5'd1;
        @(negedge clk);
        issue_valid = 1'b1; issue_reg = 5'd2;
        alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'hCAFE_0005;
        read_reg_1 = 5'd1;
        @(posedge clk); #1;
        n_checks++; if (pending !== 32'h0000_0006 || signal_reg_write !== 1'b1 || stall !== 1'b1) begin
            n_errors++; $display("FAIL midrst_pre: got pending=%h srw=%b stall=%b expected 00000006 1 1", pending, signal_reg_write, stall);
        end
        #1 reset = 1'b1;
        #1;
        n_checks++; if (pending !== 32'h0) begin n_errors++; $display("FAIL midrst_pending: got %h expected 00000000", pending); end
        n_checks++; if (signal_reg_write !== 1'b0 || stall !== 1'b0) begin n_errors++; $display("FAIL midrst_srw_stall: got srw=%b stall=%b expected 0 0", signal_reg_write, stall); end
        n_checks++; if (alu_ready !== 1'b0) begin n_errors++; $display("FAIL midrst_ready: got %b expected 0", alu_ready); end
        @(negedge clk);
        clear_inputs();
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu_only();
        test_round_robin();
        test_stall();
        test_reg_zero();
        test_set_clear_same_cycle();
        test_reset_mid_run();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mips_reg_write_scheduler.md
Name: mips_reg_write_scheduler

Overview:
Sequences the single write port of the 32x32 MIPS register file between two writeback requesters: the ALU path and the memory-load path. It also keeps a pending-destination scoreboard, so decode can stall when a source register still has a write outstanding. It sits between the execute/memory stages and the register file, and drives the register file's write_data, write_reg and signal_reg_write inputs.

Parameters:
DATA_WIDTH, 32, width of register data
ADDR_WIDTH, 5, register index width
NUM_REGS, 32, number of architectural registers (2**ADDR_WIDTH)

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-high reset
issue_valid  input  1  decode issues an instruction with a destination register
issue_reg  input  ADDR_WIDTH  destination index of the issued instruction
alu_valid  input  1  ALU writeback request
alu_reg  input  ADDR_WIDTH  ALU destination index
alu_data  input  DATA_WIDTH  ALU result
alu_ready  output  1  ALU request accepted this cycle
mem_valid  input  1  load writeback request
mem_reg  input  ADDR_WIDTH  load destination index
mem_data  input  DATA_WIDTH  load result
mem_ready  output  1  load request accepted this cycle
read_reg_1  input  ADDR_WIDTH  decode source index 1
read_reg_2  input  ADDR_WIDTH  decode source index 2
stall  output  1  a source has an outstanding or in-flight write
write_data  output  DATA_WIDTH  to register file
write_reg  output  ADDR_WIDTH  to register file
signal_reg_write  output  1  register-file write enable
pending  output  NUM_REGS  scoreboard bit vector

Behaviour:
- Reset (async, active-high):
  - write_data, write_reg, signal_reg_write and pending go to 0.
  - The last_grant flop goes to MEM.
- Handshake:
  - Transfer on valid & ready.
  - ready is combinational from the valid inputs and last_grant.
  - Requesters must hold reg/data stable while valid is high and ready is low.
- Arbitration, at most one grant per cycle:
  - Only alu_valid high: grant ALU.
  - Only mem_valid high: grant MEM.
  - Both high: grant the requester not named by last_grant (round-robin). The first tie after reset goes to ALU.
  - last_grant updates only on an actual grant.
- Write stage:
  - Granted reg/data are registered. write_data, write_reg and signal_reg_write are valid the cycle after the handshake (latency 1). The register file commits on the following rising edge.
  - signal_reg_write is a 1-cycle pulse per grant. It is 0 in cycles with no grant.
  - Write to register 0: the handshake completes, but signal_reg_write stays 0. write_reg and write_data may still update. The scoreboard is not touched.
- Scoreboard:
  - Set: pending[issue_reg] sets on issue_valid when issue_reg != 0.
  - Clear: pending[r] clears on the clock edge at which a grant for reg r occurs.
  - Same register set and cleared in one cycle: set wins (a newer producer exists).
  - Issue to an already pending register: the bit stays 1. There are no counts. Decode must not issue a second producer to a pending register.
  - pending[0] is always 0.
- stall, combinational:
  - stall = 1 if, for r in {read_reg_1, read_reg_2} with r != 0, either:
    - pending[r] = 1, or
    - signal_reg_write = 1 and write_reg = r (write in flight).
  - Register 0 never stalls.
- Reset mid-operation: in-flight writes are dropped, the scoreboard is cleared, and ready goes low while reset is high.

Decomposition:
- Shared package: DATA_WIDTH and ADDR_WIDTH constants, the GRANT_ALU/GRANT_MEM encoding, and the REG_ZERO constant.
- One natural sub-module: mips_rr_arbiter2, a 2-requester round-robin arbiter with a last_grant flop, reused by later multi-port stages.
- Scoreboard and write stage stay inline.

Test Plan:
1. Reset mid-run. Assert reset after pending = 32'h0000_0006 with a write in flight -> pending = 0, signal_reg_write = 0 and stall = 0 immediately, with no waiting for clk.
2. alu_valid only, alu_reg = 5'd30, alu_data = 32'hFF003FFF -> alu_ready = 1 in the same cycle; the next cycle shows signal_reg_write = 1, write_reg = 30, write_data = 32'hFF003FFF; it drops to 0 one cycle later.
3. Both valid for 4 consecutive cycles after reset (alu_reg = 5, mem_reg = 6) -> grant order ALU, MEM, ALU, MEM, with exactly one ready per cycle.
4. issue_valid with issue_reg = 31, then read_reg_1 = 31 -> stall = 1 until the grant for reg 31. stall remains 1 through the write-stage cycle and is 0 the cycle after.
5. mem write to reg 0 with data 32'hDEADBEEF -> mem_ready = 1, signal_reg_write stays 0, pending unchanged; issue_reg = 0 never sets pending[0].
6. Same cycle: issue_reg = 7 with a grant for reg 7 (pending[7] = 1) -> pending[7] remains 1 afterwards.
